// File: rtl/uart_bus_host.sv
// UART slave-bus initiator bridging a byte-stream client (TX in / RX out) to the UART registers.
// Define UART_HOST_RXBUF_EN to replace the single rx holding register with an RXBUF_DEPTH-entry FIFO.
module uart_bus_host #(
    parameter int TIMEOUT_CYC = 255,
    parameter int POLL_GAP    = 4,
    parameter int RXBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cs_,
    output logic        as_,
    output logic        rw,
    output logic        addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        rdy_,
    input  logic        irq_rx,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        bus_err
);
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {IDLE, RX_RD, RX_CLR, TX_POLL, TX_GAP, TX_WR} state_e;

    state_e         state_q, state_d;
    logic           hold_q, hold_d;
    logic           first_q, first_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [GCW-1:0] gap_q, gap_d;
    logic           berr_q, berr_d;
    logic           access, active, done, tmo;
    logic           rx_push, rx_pop, rx_room;

    // hold_q inserts the mandatory cs_=1 cycle when one access chains straight into another
    assign access   = (state_q == RX_RD) || (state_q == RX_CLR) || (state_q == TX_POLL) || (state_q == TX_WR);
    assign active   = access && !hold_q;
    assign done     = active && !first_q && !rdy_;
    assign tmo      = active && !first_q && rdy_ && (wait_q == WCW'(TIMEOUT_CYC - 1));
    assign cs_      = !active;
    assign as_      = !(active && first_q);
    assign tx_ready = done && (state_q == TX_WR);
    assign rx_push  = done && (state_q == RX_RD);
    assign bus_err  = berr_q;

    always_comb begin
        rw      = 1'b1;
        addr    = 1'b0;
        wr_data = '0;
        case (state_q)
            RX_RD:  addr = 1'b1;
            RX_CLR: rw = 1'b0;
            TX_WR: begin
                rw      = 1'b0;
                addr    = 1'b1;
                wr_data = {24'b0, tx_byte};
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_d = '0;
        if (active && first_q)
            wait_d = WCW'(1);
        else if (active && !done && !tmo)
            wait_d = wait_q + WCW'(1);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = 1'b0;
        first_d = hold_q;
        gap_d   = gap_q;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq_rx && rx_room) begin
                    state_d = RX_RD;
                    first_d = 1'b1;
                end else if (tx_valid) begin
                    state_d = TX_POLL;
                    first_d = 1'b1;
                end
            end
            TX_GAP: begin
                if (irq_rx && rx_room) begin
                    state_d = IDLE;
                end else if (gap_q == GCW'(POLL_GAP - 1)) begin
                    state_d = TX_POLL;
                    first_d = 1'b1;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            default: begin
                if (tmo) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end else if (done) begin
                    case (state_q)
                        RX_RD: begin
                            state_d = RX_CLR;
                            hold_d  = 1'b1;
                        end
                        TX_POLL: begin
                            if (rd_data[3]) begin
                                state_d = TX_GAP;
                                gap_d   = '0;
                            end else begin
                                state_d = TX_WR;
                                hold_d  = 1'b1;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            first_q <= 1'b0;
            wait_q  <= '0;
            gap_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            berr_q  <= berr_d;
        end
    end

    assign rx_pop = rx_valid && rx_ready;

`ifdef UART_HOST_RXBUF_EN
    localparam int PW = $clog2(RXBUF_DEPTH);

    logic [7:0]  mem_q [RXBUF_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          unused_ok;

    assign rx_room   = (cnt_q != (PW+1)'(RXBUF_DEPTH));
    assign rx_valid  = (cnt_q != '0);
    assign rx_byte   = mem_q[rd_q];
    assign unused_ok = ^rd_data[31:8];

    // power-of-2 depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RXBUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (rx_push) begin
                mem_q[wr_q] <= rd_data[7:0];
                wr_q        <= wr_q + PW'(1);
            end
            if (rx_pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(rx_push) - (PW+1)'(rx_pop);
        end
    end
`else
    logic [7:0] byte_q;
    logic       full_q;
    logic       unused_ok;

    assign rx_room   = !full_q;
    assign rx_valid  = full_q;
    assign rx_byte   = byte_q;
    assign unused_ok = ^{rd_data[31:8], (RXBUF_DEPTH > 0)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (rx_push) byte_q <= rd_data[7:0];
            full_q <= rx_push | (full_q & ~rx_pop);
        end
    end
`endif
endmodule

// File: tb/tb_uart_bus_host.sv
// Directed bench for uart_bus_host: UART slave responder, bus/handshake monitor, one task per scenario.
module tb_uart_bus_host;
    logic        clk = 1'b0;
    logic        reset;
    logic        cs_, as_, rw, addr;
    logic [31:0] wr_data, rd_data;
    logic        rdy_, irq_rx, tx_valid, tx_ready, rx_valid, rx_ready, bus_err;
    logic [7:0]  tx_byte, rx_byte;

    int checks = 0;
    int errors = 0;

`ifdef UART_HOST_RXBUF_EN
    localparam int NEXP = 4;
`else
    localparam int NEXP = 1;
`endif

    uart_bus_host dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: latency-1 responder, status/data replies from queues (0 when exhausted)
    logic [31:0] stat_q[$];
    logic [31:0] data_q[$];
    bit          hang = 1'b0;
    int          acc_cyc[$];
    logic        acc_rw[$];
    logic        acc_addr[$];
    logic [31:0] acc_wd[$];
    int          proto_err = 0;

    initial begin : slave
        logic [31:0] resp;
        logic        prev_cs;
        int          stat_rd, data_rd;
        resp = '0; prev_cs = 1'b1; stat_rd = 0; data_rd = 0;
        rdy_ = 1'b1; rd_data = '1;
        forever begin
            @(negedge clk);
            rdy_ = 1'b1;
            rd_data = '1;
            if (!cs_ && !as_) begin
                if (!prev_cs) proto_err++;
                acc_cyc.push_back(cyc); acc_rw.push_back(rw);
                acc_addr.push_back(addr); acc_wd.push_back(wr_data);
                resp = '0;
                if (rw && !addr && stat_rd < stat_q.size()) begin resp = stat_q[stat_rd]; stat_rd++; end
                if (rw && addr && data_rd < data_q.size()) begin resp = data_q[data_rd]; data_rd++; end
            end else if (!cs_ && !hang) begin
                rdy_ = 1'b0;
                rd_data = resp;
            end
            prev_cs = cs_;
        end
    end

    int   txr_cnt = 0, berr_cnt = 0, berr_cyc = 0, berr_run = 0, run = 0;
    logic berr_cs = 1'b0;
    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            if (tx_ready) txr_cnt++;
            if (bus_err) begin berr_cnt++; berr_cyc = cyc; berr_cs = cs_; berr_run = run; end
            if (!cs_) run++; else run = 0;
        end
    end

    task automatic wait_tx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (tx_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pop_byte(output logic [7:0] v, output bit ok);
        ok = 1'b0; v = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (rx_valid) begin
                ok = 1'b1; v = rx_byte; rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; irq_rx = 1'b0; tx_valid = 1'b0; tx_byte = '0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({cs_, as_, rw, addr} !== 4'b1110) begin errors++; $display("FAIL reset_bus: got %b exp 1110", {cs_, as_, rw, addr}); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h exp 0", wr_data); end
        checks++; if ({tx_ready, rx_valid, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {tx_ready, rx_valid, bus_err}); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h exp 00", rx_byte); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_tx();
        int b, t0, pe; bit ok;
        b = acc_cyc.size(); t0 = txr_cnt; pe = proto_err;
        tx_byte = 8'h55; tx_valid = 1'b1;
        wait_tx(50, ok);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL single_tx_ready: got none exp pulse"); end
        checks++; if (acc_cyc.size() - b !== 2) begin errors++; $display("FAIL single_tx_count: got %0d exp 2", acc_cyc.size() - b); end
        if (acc_cyc.size() >= b + 2) begin
            checks++; if ({acc_rw[b], acc_addr[b]} !== 2'b10) begin errors++; $display("FAIL single_tx_poll: got rw/addr %b exp 10", {acc_rw[b], acc_addr[b]}); end
            checks++; if ({acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]} !== {2'b01, 32'h55}) begin errors++; $display("FAIL single_tx_write: got %b %b %h exp 0 1 00000055", acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]); end
            checks++; if (acc_cyc[b+1] - acc_cyc[b] !== 3) begin errors++; $display("FAIL single_tx_spacing: got %0d exp 3", acc_cyc[b+1] - acc_cyc[b]); end
        end
        checks++; if (txr_cnt - t0 !== 1) begin errors++; $display("FAIL single_tx_pulses: got %0d exp 1", txr_cnt - t0); end
        checks++; if (proto_err !== pe) begin errors++; $display("FAIL single_tx_gap: got %0d violations exp 0", proto_err - pe); end
    endtask

    task automatic test_busy_poll();
        int b; bit ok;
        int exp_gap[3] = '{6, 6, 3};
        b = acc_cyc.size();
        stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h0);
        tx_byte = 8'hC3; tx_valid = 1'b1;
        wait_tx(100, ok);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL busy_poll_ready: got none exp pulse"); end
        checks++; if (acc_cyc.size() - b !== 4) begin errors++; $display("FAIL busy_poll_count: got %0d exp 4", acc_cyc.size() - b); end
        if (acc_cyc.size() >= b + 4) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if ({acc_rw[b+i], acc_addr[b+i]} !== 2'b10) begin errors++; $display("FAIL busy_poll_read%0d: got rw/addr %b exp 10", i, {acc_rw[b+i], acc_addr[b+i]}); end
                checks++; if (acc_cyc[b+i+1] - acc_cyc[b+i] !== exp_gap[i]) begin errors++; $display("FAIL busy_poll_spacing%0d: got %0d exp %0d", i, acc_cyc[b+i+1] - acc_cyc[b+i], exp_gap[i]); end
            end
            checks++; if ({acc_rw[b+3], acc_addr[b+3], acc_wd[b+3]} !== {2'b01, 32'hC3}) begin errors++; $display("FAIL busy_poll_write: got %b %b %h exp 0 1 000000c3", acc_rw[b+3], acc_addr[b+3], acc_wd[b+3]); end
        end
    endtask

    task automatic test_receive();
        int b; logic [7:0] v; bit ok;
        b = acc_cyc.size();
        data_q.push_back(32'h0000_00A7);
        irq_rx = 1'b1;
        for (int i = 0; i < 50 && acc_cyc.size() < b + 2; i++) @(negedge clk);
        irq_rx = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (acc_cyc.size() - b !== 2) begin errors++; $display("FAIL receive_count: got %0d exp 2", acc_cyc.size() - b); end
        if (acc_cyc.size() >= b + 2) begin
            checks++; if ({acc_rw[b], acc_addr[b]} !== 2'b11) begin errors++; $display("FAIL receive_read: got rw/addr %b exp 11", {acc_rw[b], acc_addr[b]}); end
            checks++; if ({acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]} !== {2'b00, 32'h0}) begin errors++; $display("FAIL receive_clear: got %b %b %h exp 0 0 00000000", acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]); end
            checks++; if (acc_cyc[b+1] - acc_cyc[b] !== 3) begin errors++; $display("FAIL receive_spacing: got %0d exp 3", acc_cyc[b+1] - acc_cyc[b]); end
        end
        checks++; if ({rx_valid, rx_byte} !== {1'b1, 8'hA7}) begin errors++; $display("FAIL receive_byte: got valid %b byte %h exp 1 a7", rx_valid, rx_byte); end
        pop_byte(v, ok);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL receive_pop: got rx_valid %b exp 0", rx_valid); end
    endtask

    task automatic test_priority();
        int b; logic [7:0] v; bit ok;
        b = acc_cyc.size();
        data_q.push_back(32'h0000_005E);
        irq_rx = 1'b1; tx_byte = 8'h81; tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc_cyc.size() >= b + 2) irq_rx = 1'b0;
            if (tx_ready) begin ok = 1'b1; break; end
        end
        tx_valid = 1'b0; irq_rx = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok || acc_cyc.size() - b !== 4) begin errors++; $display("FAIL priority_count: got %0d accesses ready %b exp 4 1", acc_cyc.size() - b, ok); end
        if (acc_cyc.size() >= b + 4) begin
            checks++; if ({acc_rw[b], acc_addr[b], acc_rw[b+1], acc_addr[b+1], acc_rw[b+2], acc_addr[b+2], acc_rw[b+3], acc_addr[b+3]} !== 8'b11_00_10_01)
                begin errors++; $display("FAIL priority_order: got %b exp 11001001", {acc_rw[b], acc_addr[b], acc_rw[b+1], acc_addr[b+1], acc_rw[b+2], acc_addr[b+2], acc_rw[b+3], acc_addr[b+3]}); end
            checks++; if (acc_wd[b+3] !== 32'h81) begin errors++; $display("FAIL priority_wdata: got %h exp 00000081", acc_wd[b+3]); end
        end
        pop_byte(v, ok);
        checks++; if (!ok || v !== 8'h5E) begin errors++; $display("FAIL priority_rx: got %h exp 5e", v); end
    endtask

    task automatic test_timeout();
        int b, e0, t0; bit seen, ok;
        b = acc_cyc.size(); e0 = berr_cnt; t0 = txr_cnt;
        hang = 1'b1; tx_byte = 8'h9A; tx_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (bus_err) begin seen = 1'b1; hang = 1'b0; break; end
        end
        hang = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL timeout_seen: got no bus_err exp pulse"); end
        checks++; if (txr_cnt !== t0) begin errors++; $display("FAIL timeout_pending: got %0d tx_ready pulses exp 0", txr_cnt - t0); end
        wait_tx(50, ok);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_retry: got no tx_ready exp pulse"); end
        checks++; if (berr_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d exp 1", berr_cnt - e0); end
        if (acc_cyc.size() >= b + 3) begin
            checks++; if (berr_cyc - acc_cyc[b] !== 255) begin errors++; $display("FAIL timeout_latency: got %0d exp 255", berr_cyc - acc_cyc[b]); end
            checks++; if ({berr_cs, berr_run} !== {1'b1, 32'd255}) begin errors++; $display("FAIL timeout_release: got cs_ %b low-run %0d exp 1 255", berr_cs, berr_run); end
            checks++; if (acc_cyc[b+1] - acc_cyc[b] !== 256) begin errors++; $display("FAIL timeout_restart: got %0d exp 256", acc_cyc[b+1] - acc_cyc[b]); end
            checks++; if ({acc_rw[b+2], acc_addr[b+2], acc_wd[b+2]} !== {2'b01, 32'h9A}) begin errors++; $display("FAIL timeout_write: got %b %b %h exp 0 1 0000009a", acc_rw[b+2], acc_addr[b+2], acc_wd[b+2]); end
        end else begin
            checks++; errors++; $display("FAIL timeout_count: got %0d accesses exp 3", acc_cyc.size() - b);
        end
    endtask

    task automatic test_backpressure();
        int b, nrd, nrd2; logic [7:0] v; bit ok;
        logic [7:0] got[$];
        b = acc_cyc.size();
        for (int i = 1; i <= 5; i++) data_q.push_back(32'(8'h11 * i));
        rx_ready = 1'b0; irq_rx = 1'b1;
        repeat (80) @(negedge clk);
        nrd = 0;
        for (int i = b; i < acc_cyc.size(); i++) if (acc_rw[i] && acc_addr[i]) nrd++;
        checks++; if (nrd !== NEXP) begin errors++; $display("FAIL backpressure_reads: got %0d exp %0d", nrd, NEXP); end
        checks++; if (acc_cyc.size() - b !== 2 * NEXP) begin errors++; $display("FAIL backpressure_stall: got %0d accesses exp %0d", acc_cyc.size() - b, 2 * NEXP); end
        pop_byte(v, ok);
        got.push_back(v);
        repeat (30) @(negedge clk);
        nrd2 = 0;
        for (int i = b; i < acc_cyc.size(); i++) if (acc_rw[i] && acc_addr[i]) nrd2++;
        checks++; if (nrd2 !== NEXP + 1) begin errors++; $display("FAIL backpressure_resume: got %0d reads exp %0d", nrd2, NEXP + 1); end
        irq_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < NEXP; i++) begin pop_byte(v, ok); got.push_back(v); end
        for (int i = 0; i <= NEXP; i++) begin
            checks++; if (got[i] !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL backpressure_order%0d: got %h exp %h", i, got[i], 8'(8'h11 * (i + 1))); end
        end
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL backpressure_drain: got rx_valid %b exp 0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        int b; bit ok;
        hang = 1'b1; tx_byte = 8'h42; tx_valid = 1'b1;
        for (int i = 0; i < 20 && cs_ !== 1'b0; i++) begin @(negedge clk); #1; end
        @(negedge clk); #3;
        reset = 1'b0;
        #1;
        checks++; if ({cs_, as_} !== 2'b11) begin errors++; $display("FAIL reset_mid_release: got cs_/as_ %b exp 11", {cs_, as_}); end
        @(negedge clk);
        reset = 1'b1; hang = 1'b0;
        b = acc_cyc.size();
        wait_tx(50, ok);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok || acc_cyc.size() - b !== 2) begin errors++; $display("FAIL reset_mid_recover: got %0d accesses ready %b exp 2 1", acc_cyc.size() - b, ok); end
        if (acc_cyc.size() >= b + 2) begin
            checks++; if ({acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]} !== {2'b01, 32'h42}) begin errors++; $display("FAIL reset_mid_write: got %b %b %h exp 0 1 00000042", acc_rw[b+1], acc_addr[b+1], acc_wd[b+1]); end
        end
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL cs_gap_total: got %0d violations exp 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_busy_poll();
        test_receive();
        test_priority();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
